// File: rtl/btn_evt_sched_pkg.sv
// btn_evt_pkg: event type codes, pending-bit indices and channel FSM states
// shared by the switch front end.
package btn_evt_pkg;
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} ch_state_t;
    localparam logic [1:0] EVT_PRESS = 2'b01;
    localparam logic [1:0] EVT_REL   = 2'b10;
    localparam logic [1:0] EVT_LONG  = 2'b11;
    localparam int P_PRESS = 0;
    localparam int P_LONG  = 1;
    localparam int P_REL   = 2;
endpackage

// File: rtl/btn_evt_sched_if.sv
// btn_evt_sched_if: valid/ready event stream carrying channel and event type.
interface btn_evt_sched_if #(parameter int N_CH = 4) ();
    logic                    evt_valid;
    logic                    evt_ready;
    logic [$clog2(N_CH)-1:0] evt_ch;
    logic [1:0]              evt_type;
    modport master (output evt_valid, evt_ch, evt_type, input evt_ready);
    modport slave  (input evt_valid, evt_ch, evt_type, output evt_ready);
endinterface

// File: rtl/btn_evt_sched_db_chan.sv
// db_chan: one switch channel - synchroniser, debounce FSM, long-press counter
// and the three pending event bits (press, long, release).
module db_chan
    import btn_evt_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sw,
    input  logic       tick,
    input  logic [2:0] clr,
    output logic       db,
    output logic [2:0] pend,
    output logic       ovf
);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int LW = $clog2(LONG_TICKS + 1);

    logic [1:0]    sync_ff;
    logic          in;
    ch_state_t     state, state_n;
    logic [SW-1:0] cnt, cnt_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic          press, rel, long_hit;
    logic [2:0]    set;

    assign in = sync_ff[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '0;
            state   <= ZERO;
            cnt     <= '0;
            lcnt    <= '0;
            pend    <= '0;
        end else begin
            sync_ff <= {sync_ff[0], sw};
            state   <= state_n;
            cnt     <= cnt_n;
            lcnt    <= lcnt_n;
            pend    <= (pend & ~clr) | set;
        end
    end

    // Stable-tick count resets on any state change or disagreeing sample.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            ZERO:  if (in) state_n = WAIT1;
            WAIT1: if (!in) state_n = ZERO;
                   else if (tick && cnt == SW'(STABLE_TICKS - 1)) state_n = ONE;
                   else cnt_n = cnt + SW'(tick);
            ONE:   if (!in) state_n = WAIT0;
            WAIT0: if (in) state_n = ONE;
                   else if (tick && cnt == SW'(STABLE_TICKS - 1)) state_n = ZERO;
                   else cnt_n = cnt + SW'(tick);
        endcase
    end

    assign db       = (state == ONE) || (state == WAIT0);
    assign press    = (state == WAIT1) && (state_n == ONE);
    assign rel      = (state == WAIT0) && (state_n == ZERO);
    assign long_hit = db && tick && (lcnt == LW'(LONG_TICKS - 1));
    assign lcnt_n   = press ? '0 : (db && tick && lcnt != LW'(LONG_TICKS)) ? lcnt + 1'b1 : lcnt;
    assign set      = {rel, long_hit, press};
    assign ovf      = |(set & pend & ~clr);
endmodule

// File: rtl/btn_evt_sched.sv
// btn_evt_sched: N_CH debounced switches with shared tick; press/release/long
// events serialised round-robin onto one valid/ready stream.
module btn_evt_sched
    import btn_evt_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_BITS    = 5,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH-1:0]      sw,
    output logic [N_CH-1:0]      db,
    output logic                 evt_ovf,
    input  logic                 ovf_clr,
    btn_evt_sched_if.master      evt
);
    localparam int CW = $clog2(N_CH);

    logic [TICK_BITS-1:0] tcnt;
    logic                 tick, load, found;
    logic [2:0]           pend [N_CH];
    logic [2:0]           clr  [N_CH];
    logic [N_CH-1:0]      ovf;
    logic [CW-1:0]        ptr, win;
    logic [2:0]           wbits, wclr;

    assign tick = (tcnt == '0);
    assign load = !evt.evt_valid || evt.evt_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        db_chan #(.STABLE_TICKS(STABLE_TICKS), .LONG_TICKS(LONG_TICKS)) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .sw      (sw[g]),
            .tick    (tick),
            .clr     (clr[g]),
            .db      (db[g]),
            .pend    (pend[g]),
            .ovf     (ovf[g])
        );
    end

    // Scan from the round-robin pointer; within the winner press > long > release.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && |pend[(int'(ptr) + i) % N_CH]) begin
                found = 1'b1;
                win   = CW'((int'(ptr) + i) % N_CH);
            end
        end
        wbits = pend[win];
        wclr  = wbits[P_PRESS] ? 3'b001 : wbits[P_LONG] ? 3'b010 : 3'b100;
        for (int c = 0; c < N_CH; c++)
            clr[c] = (load && found && win == CW'(c)) ? wclr : 3'b000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt           <= '0;
            ptr            <= '0;
            evt_ovf        <= 1'b0;
            evt.evt_valid  <= 1'b0;
            evt.evt_ch     <= '0;
            evt.evt_type   <= '0;
        end else begin
            tcnt    <= tcnt + 1'b1;
            evt_ovf <= |ovf || (evt_ovf && !ovf_clr);
            if (load) begin
                evt.evt_valid <= found;
                if (found) begin
                    evt.evt_ch   <= win;
                    evt.evt_type <= wbits[P_PRESS] ? EVT_PRESS : wbits[P_LONG] ? EVT_LONG : EVT_REL;
                    ptr          <= (win == CW'(N_CH - 1)) ? '0 : win + 1'b1;
                end
            end
        end
    end
endmodule
